pc_npc_unit: RTL and testbench

- Parametrised program-counter unit for the pipelined MIPS core: holds the PC/nPC register pair that implements the one-instruction branch delay slot.
- Selects the next fetch address from sequential increment, branch target, jump target or exception vector.
- Holds off redirects that arrive while the fetch stage is stalled and applies them when the stall releases.
- Sits at the head of the IF stage; `pc` drives instruction memory.

---
 rtl/mips_pkg.sv | 19 +
 rtl/npc_select.sv | 42 ++++
 rtl/pc_npc_unit.sv | 109 ++++++++++
 tb/tb_pc_npc_unit.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch front end: PC source encodings,
// PC unit state and the default exception vector.
package mips_pkg;

  typedef enum logic [1:0] {
    PCSRC_SEQ  = 2'b00,
    PCSRC_BRJ  = 2'b01,
    PCSRC_EXC  = 2'b10,
    PCSRC_PEND = 2'b11
  } pcsrc_e;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } pc_state_e;

  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h0000_0080;

endpackage

// File: rtl/npc_select.sv
// Combinational next-npc selection: resolves redirect priority (jump over branch)
// and picks the next npc among exception, live redirect, replayed redirect and increment.
module npc_select
  import mips_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] INC        = 'd4,
  parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(EXC_VECTOR_DEFAULT)
) (
  input  logic [WIDTH-1:0] npc_i,
  input  logic             branch_taken_i,
  input  logic [WIDTH-1:0] branch_target_i,
  input  logic             jump_i,
  input  logic [WIDTH-1:0] jump_target_i,
  input  logic             exc_req_i,
  input  logic             pending_i,
  input  logic [WIDTH-1:0] pending_target_i,
  output logic             redirect_o,
  output logic [WIDTH-1:0] redirect_target_o,
  output logic [WIDTH-1:0] npc_next_o,
  output pcsrc_e           src_o
);

  always_comb begin
    redirect_o        = branch_taken_i | jump_i;
    redirect_target_o = jump_i ? jump_target_i : branch_target_i;
    npc_next_o        = npc_i + INC;
    src_o             = PCSRC_SEQ;
    // A live redirect outranks a replayed one: the newer control flow wins.
    if (exc_req_i) begin
      npc_next_o = EXC_VECTOR + INC;
      src_o      = PCSRC_EXC;
    end else if (redirect_o) begin
      npc_next_o = redirect_target_o;
      src_o      = PCSRC_BRJ;
    end else if (pending_i) begin
      npc_next_o = pending_target_i;
      src_o      = PCSRC_PEND;
    end
  end

endmodule

// File: rtl/pc_npc_unit.sv
// PC/nPC register pair with one-instruction branch delay slot; redirects seen
// during a fetch stall are latched and replayed when the stall releases.
module pc_npc_unit
  import mips_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_PC   = '0,
  parameter logic [WIDTH-1:0] INC        = 'd4,
  parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(EXC_VECTOR_DEFAULT)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             le,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             exc_req,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] npc,
  output logic [1:0]       pc_source_select,
  output logic             redirect_pending,
  output logic             target_misaligned
);

  localparam logic [WIDTH-1:0] RESET_NPC = RESET_PC + INC;

  pc_state_e        state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] npc_q, npc_d;
  logic [WIDTH-1:0] pend_tgt_q, pend_tgt_d;
  pcsrc_e           src_q, src_d;
  logic             mis_q, mis_d;

  logic             redirect;
  logic [WIDTH-1:0] redirect_target;
  logic [WIDTH-1:0] npc_next;
  pcsrc_e           sel_src;

  npc_select #(
    .WIDTH      (WIDTH),
    .INC        (INC),
    .EXC_VECTOR (EXC_VECTOR)
  ) u_npc_select (
    .npc_i             (npc_q),
    .branch_taken_i    (branch_taken),
    .branch_target_i   (branch_target),
    .jump_i            (jump),
    .jump_target_i     (jump_target),
    .exc_req_i         (exc_req),
    .pending_i         (state_q == HOLD),
    .pending_target_i  (pend_tgt_q),
    .redirect_o        (redirect),
    .redirect_target_o (redirect_target),
    .npc_next_o        (npc_next),
    .src_o             (sel_src)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    npc_d      = npc_q;
    pend_tgt_d = pend_tgt_q;
    src_d      = src_q;
    mis_d      = mis_q;
    if (exc_req) begin
      pc_d    = EXC_VECTOR;
      npc_d   = npc_next;
      src_d   = sel_src;
      state_d = RUN;
      mis_d   = 1'b0;
    end else if (le) begin
      pc_d    = npc_q;
      npc_d   = npc_next;
      src_d   = sel_src;
      state_d = RUN;
      // Only target loads can be misaligned; a sequential load clears the flag.
      mis_d   = (sel_src == PCSRC_SEQ) ? 1'b0 : (npc_next[1:0] != 2'b00);
    end else if (redirect) begin
      pend_tgt_d = redirect_target;
      state_d    = HOLD;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      npc_q      <= RESET_NPC;
      pend_tgt_q <= '0;
      src_q      <= PCSRC_SEQ;
      mis_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      npc_q      <= npc_d;
      pend_tgt_q <= pend_tgt_d;
      src_q      <= src_d;
      mis_q      <= mis_d;
    end
  end

  assign pc                = pc_q;
  assign npc               = npc_q;
  assign pc_source_select  = src_q;
  assign redirect_pending  = (state_q == HOLD);
  assign target_misaligned = mis_q;

endmodule

// File: tb/tb_pc_npc_unit.sv
// Scoreboard bench for pc_npc_unit: two instances (RESET_PC 0 and 0xFFFF_FFFC)
// share one stimulus stream and are compared against a behavioural model.
module tb_pc_npc_unit;

  localparam logic [31:0] RPC0 = 32'h0000_0000;
  localparam logic [31:0] RPC1 = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        reset = 1'b1, le = 1'b0, branch_taken = 1'b0, jump = 1'b0, exc_req = 1'b0;
  logic [31:0] branch_target = '0, jump_target = '0;

  logic [31:0] pc0, npc0, pc1, npc1;
  logic [1:0]  sel0, sel1;
  logic        pend0, pend1, mis0, mis1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pc_npc_unit #(.WIDTH(32), .RESET_PC(RPC0)) dut0 (
    .clk(clk), .reset(reset), .le(le),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target), .exc_req(exc_req),
    .pc(pc0), .npc(npc0), .pc_source_select(sel0),
    .redirect_pending(pend0), .target_misaligned(mis0)
  );

  pc_npc_unit #(.WIDTH(32), .RESET_PC(RPC1)) dut1 (
    .clk(clk), .reset(reset), .le(le),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target), .exc_req(exc_req),
    .pc(pc1), .npc(npc1), .pc_source_select(sel1),
    .redirect_pending(pend1), .target_misaligned(mis1)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] npc;
    logic [1:0]  src;
    logic        pend;
    logic [31:0] ptgt;
    logic        mis;
  } mstate_t;

  typedef struct {
    mstate_t a;
    mstate_t b;
  } exp_t;

  mstate_t m0, m1;
  exp_t    sb[$];

  // Architectural rules: reset > exception > stall/advance; jump beats branch;
  // a stalled redirect is remembered and delivered once fetch resumes.
  function automatic mstate_t model_step(mstate_t s, logic [31:0] rpc, logic r, logic l,
                                         logic bt, logic [31:0] btg, logic j,
                                         logic [31:0] jtg, logic ex);
    mstate_t n = s;
    logic [31:0] tgt = j ? jtg : btg;
    if (r) begin
      n.pc = rpc; n.npc = rpc + 32'd4; n.src = 2'b00; n.pend = 1'b0; n.ptgt = '0; n.mis = 1'b0;
    end else if (ex) begin
      n.pc = 32'h80; n.npc = 32'h84; n.src = 2'b10; n.pend = 1'b0; n.mis = 1'b0;
    end else if (l) begin
      n.pc = s.npc;
      if (bt || j) begin
        n.npc = tgt; n.src = 2'b01; n.mis = (tgt % 4) != 0;
      end else if (s.pend) begin
        n.npc = s.ptgt; n.src = 2'b11; n.mis = (s.ptgt % 4) != 0;
      end else begin
        n.npc = s.npc + 32'd4; n.src = 2'b00; n.mis = 1'b0;
      end
      n.pend = 1'b0;
    end else if (bt || j) begin
      n.ptgt = tgt; n.pend = 1'b1;
    end
    return n;
  endfunction

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic l, input logic bt, input logic [31:0] btg,
                      input logic j, input logic [31:0] jtg, input logic ex);
    exp_t e;
    @(negedge clk);
    reset = r; le = l; branch_taken = bt; branch_target = btg;
    jump = j; jump_target = jtg; exc_req = ex;
    m0 = model_step(m0, RPC0, r, l, bt, btg, j, jtg, ex);
    m1 = model_step(m1, RPC1, r, l, bt, btg, j, jtg, ex);
    e.a = m0; e.b = m1;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: one observation per cycle, checked against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        cmp("dut0_pc",   pc0,           e.a.pc);
        cmp("dut0_npc",  npc0,          e.a.npc);
        cmp("dut0_sel",  {30'd0, sel0}, {30'd0, e.a.src});
        cmp("dut0_pend", {31'd0, pend0}, {31'd0, e.a.pend});
        cmp("dut0_mis",  {31'd0, mis0}, {31'd0, e.a.mis});
        cmp("dut1_pc",   pc1,           e.b.pc);
        cmp("dut1_npc",  npc1,          e.b.npc);
        cmp("dut1_sel",  {30'd0, sel1}, {30'd0, e.b.src});
        cmp("dut1_pend", {31'd0, pend1}, {31'd0, e.b.pend});
        cmp("dut1_mis",  {31'd0, mis1}, {31'd0, e.b.mis});
      end
    end
  end

  initial begin
    logic r, l, bt, j, ex;
    logic [31:0] btg, jtg;
    int guard;
    m0 = '{default: '0};
    m1 = '{default: '0};

    step(1, 0, 0, 0, 0, 0, 0);
    cmp("rst_pc", pc0, 32'h0);
    cmp("rst_npc", npc0, 32'h4);
    cmp("rst1_npc_wrap", npc1, 32'h0);
    step(0, 1, 0, 0, 0, 0, 0);
    cmp("seq_pc", pc0, 32'h4);
    cmp("wrap_pc", pc1, 32'h0);
    cmp("wrap_npc", npc1, 32'h4);
    step(0, 1, 0, 0, 0, 0, 0);
    cmp("seq_pc8", pc0, 32'h8);
    step(0, 1, 1, 32'h40, 0, 0, 0);
    cmp("br_pc", pc0, 32'hC);
    cmp("br_npc", npc0, 32'h40);
    cmp("br_sel", {30'd0, sel0}, 32'd1);
    step(0, 1, 0, 0, 0, 0, 0);
    cmp("br_pc2", pc0, 32'h40);
    cmp("br_npc2", npc0, 32'h44);
    step(0, 0, 0, 0, 1, 32'h100, 0);
    cmp("hold_pend", {31'd0, pend0}, 32'd1);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    cmp("hold_pc", pc0, 32'h40);
    step(0, 1, 0, 0, 0, 0, 0);
    cmp("replay_npc", npc0, 32'h100);
    cmp("replay_sel", {30'd0, sel0}, 32'd3);
    cmp("replay_pend", {31'd0, pend0}, 32'd0);
    step(0, 1, 1, 32'h20, 1, 32'h30, 0);
    cmp("jump_prio", npc0, 32'h30);
    step(0, 0, 0, 0, 1, 32'h200, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    cmp("exc_pc", pc0, 32'h80);
    cmp("exc_npc", npc0, 32'h84);
    cmp("exc_sel", {30'd0, sel0}, 32'd2);
    step(0, 1, 0, 0, 1, 32'h102, 0);
    cmp("misalign", {31'd0, mis0}, 32'd1);
    step(0, 0, 0, 0, 1, 32'h50, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    cmp("rst_hold_pc", pc0, 32'h0);
    cmp("rst_hold_pend", {31'd0, pend0}, 32'd0);

    for (int i = 0; i < 400; i++) begin
      r   = ($urandom_range(0, 99) < 2);
      l   = ($urandom_range(0, 99) < 65);
      bt  = ($urandom_range(0, 99) < 15);
      j   = ($urandom_range(0, 99) < 10);
      ex  = ($urandom_range(0, 99) < 3);
      btg = $urandom() & ((($urandom_range(0, 3)) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
      jtg = $urandom() & ((($urandom_range(0, 3)) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
      step(r, l, bt, btg, j, jtg, ex);
    end

    @(negedge clk);
    le = 1'b0; branch_taken = 1'b0; jump = 1'b0; exc_req = 1'b0;
    guard = 0;
    while (sb.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    #2;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
